// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain stage for an asynchronous FIFO, living entirely in the read
// clock domain. Converts the FIFO pop/empty port (data valid one cycle after
// pop) into a valid/ready stream backed by a registered 2-entry buffer, and
// counts completed stream handshakes.
//
// Parameters:
//   DATA_WIDTH - width of a FIFO word / stream beat
//   CNT_WIDTH  - width of the delivered-word counter
//
// Ports:
//   rdclk    in   read-domain clock
//   rd_rst   in   asynchronous active-high reset
//   enable   in   permits new pops when high
//   empty    in   FIFO empty flag
//   pop      out  FIFO read request
//   data_out in   FIFO read data, valid the cycle after an accepted pop
//   m_data   out  stream data (head of the buffer)
//   m_valid  out  stream valid
//   m_ready  in   stream ready from the consumer
//   word_cnt out  number of completed stream handshakes (wraps)
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  empty,
    output logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [DATA_WIDTH-1:0] slot0_reg, slot0_next;
    logic [DATA_WIDTH-1:0] slot1_reg, slot1_next;
    logic [1:0]            occ_reg, occ_next;
    logic                  infl_reg;
    logic [CNT_WIDTH-1:0]  word_cnt_reg, word_cnt_next;

    logic                  drain;
    logic [1:0]            post_occ;
    logic [2:0]            pending;

    assign m_valid = (occ_reg != 2'd0);
    assign m_data  = slot0_reg;
    assign drain   = m_valid & m_ready;

    // Slots that will be committed once this cycle's drain and any in-flight
    // word are accounted for. Issuing a pop only while this is below 2 keeps
    // occ + infl <= 2, so a capture always finds a free slot.
    assign pending = {1'b0, occ_reg} + {2'b00, infl_reg} - {2'b00, drain};
    assign pop     = ~rd_rst & enable & ~empty & (pending < 3'd2);

    // Occupancy after the head leaves; drain implies occ >= 1, so no underflow.
    assign post_occ = occ_reg - {1'b0, drain};

    always_comb begin
        slot0_next    = slot0_reg;
        slot1_next    = slot1_reg;
        occ_next      = post_occ + {1'b0, infl_reg};
        word_cnt_next = word_cnt_reg;

        if (drain) begin
            slot0_next    = slot1_reg;
            word_cnt_next = word_cnt_reg + 1'b1;
        end

        // The arriving word goes to the first free slot after the shift;
        // this overrides the shift into slot0 when the buffer just emptied.
        if (infl_reg) begin
            if (post_occ == 2'd0) begin
                slot0_next = data_out;
            end else begin
                slot1_next = data_out;
            end
        end
    end

    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            slot0_reg    <= '0;
            slot1_reg    <= '0;
            occ_reg      <= 2'd0;
            infl_reg     <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            slot0_reg    <= slot0_next;
            slot1_reg    <= slot1_next;
            occ_reg      <= occ_next;
            infl_reg     <= pop;
            word_cnt_reg <= word_cnt_next;
        end
    end

    assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream. A tiny FIFO model supplies empty and
// data_out (one cycle after pop). Each cycle's pop/valid/ready/data/count are
// logged on the falling edge and compared against hand-derived expectations.
// The DUT is built with CNT_WIDTH=4 so the counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rdclk = 1'b0;
    logic          rd_rst;
    logic          enable;
    logic          empty;
    logic          pop;
    logic [DW-1:0] data_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] word_cnt;

    always #5 rdclk = ~rdclk;

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .rdclk   (rdclk),
        .rd_rst  (rd_rst),
        .enable  (enable),
        .empty   (empty),
        .pop     (pop),
        .data_out(data_out),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .word_cnt(word_cnt)
    );

    // FIFO model: contents written by the stimulus, read pointer advanced by pop
    logic [DW-1:0] fifo_mem [0:63];
    int            wr_cnt = 0;
    int            rd_idx = 0;
    logic          fifo_clr = 1'b0;

    assign empty = (rd_idx == wr_cnt);

    always @(posedge rdclk) begin
        if (fifo_clr) begin
            rd_idx <= 0;
        end else if (pop) begin
            data_out <= fifo_mem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // per-cycle log
    logic          lp [0:63];
    logic          lv [0:63];
    logic          lr [0:63];
    logic [DW-1:0] ld [0:63];
    logic [CW-1:0] lc [0:63];
    int            log_n = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // record the current cycle on the falling edge, then advance to just
    // after the next rising edge where new inputs are applied
    task automatic step();
        @(negedge rdclk);
        if (log_n < 64) begin
            lp[log_n] = pop;
            lv[log_n] = m_valid;
            lr[log_n] = m_ready;
            ld[log_n] = m_data;
            lc[log_n] = word_cnt;
        end
        log_n++;
        @(posedge rdclk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_mem[wr_cnt] = v;
        wr_cnt++;
    endtask

    task automatic start_test();
        rd_rst   = 1'b1;
        fifo_clr = 1'b1;
        wr_cnt   = 0;
        step();
        fifo_clr = 1'b0;
        log_n    = 0;
    endtask

    task automatic release_rst();
        rd_rst = 1'b0;
        log_n  = 0;
    endtask

    function automatic int count_pops();
        int n = 0;
        for (int i = 0; i < log_n && i < 64; i++) if (lp[i]) n++;
        return n;
    endfunction

    function automatic int first_pop();
        for (int i = 0; i < log_n && i < 64; i++) if (lp[i]) return i;
        return -1;
    endfunction

    // deliveries must be first_val, first_val+1, ... on consecutive cycles
    task automatic check_deliveries(input string tag, input int first_val,
                                    input int n_exp, input int first_cycle);
        int k = 0;
        for (int i = 0; i < log_n && i < 64; i++) begin
            if (lv[i] && lr[i]) begin
                $display("%s: word %0d data %02h cycle %0d", tag, k, ld[i], i);
                chk({tag, "_data"}, {24'd0, ld[i]}, (first_val + k) & 8'hFF);
                chk({tag, "_cyc"}, i, first_cycle + k);
                k++;
            end
        end
        chk({tag, "_n"}, k, n_exp);
    endtask

    initial begin
        rd_rst  = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;

        // reset values
        start_test();
        chk("reset_valid", {31'd0, m_valid}, 0);
        chk("reset_pop", {31'd0, pop}, 0);
        chk("reset_wcnt", {28'd0, word_cnt}, 0);
        chk("reset_data", {24'd0, m_data}, 0);

        // streaming: 0x01..0x08 at full rate
        for (int i = 1; i <= 8; i++) push(i[7:0]);
        m_ready = 1'b1;
        enable  = 1'b1;
        release_rst();
        repeat (12) step();
        chk("strm_pops", count_pops(), 8);
        chk("strm_first_pop", first_pop(), 0);
        check_deliveries("strm", 1, 8, 2);
        chk("strm_wcnt", {28'd0, word_cnt}, 8);

        // backpressure: 5 queued, consumer stalled
        start_test();
        for (int i = 1; i <= 5; i++) push(i[7:0]);
        m_ready = 1'b0;
        enable  = 1'b1;
        release_rst();
        repeat (6) step();
        chk("bp_pops", count_pops(), 2);
        chk("bp_pop0", {31'd0, lp[0]}, 1);
        chk("bp_pop1", {31'd0, lp[1]}, 1);
        for (int i = 2; i < 6; i++) begin
            chk("bp_hold_valid", {31'd0, lv[i]}, 1);
            chk("bp_hold_data", {24'd0, ld[i]}, 8'h01);
        end
        m_ready = 1'b1;
        log_n   = 0;
        repeat (10) step();
        check_deliveries("bp", 1, 5, 0);
        chk("bp_wcnt", {28'd0, word_cnt}, 5);
        chk("bp_end_valid", {31'd0, m_valid}, 0);

        // reset mid-operation with one word buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h21 + i[7:0]);
        log_n = 0;
        step();
        step();
        chk("pre_rst_valid", {31'd0, m_valid}, 1);
        chk("pre_rst_data", {24'd0, m_data}, 8'h21);
        chk("pre_rst_wcnt", {28'd0, word_cnt}, 5);
        rd_rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_pop", {31'd0, pop}, 0);
        chk("rst_wcnt", {28'd0, word_cnt}, 0);
        chk("rst_data", {24'd0, m_data}, 0);
        start_test();
        push(8'h11);
        m_ready = 1'b1;
        release_rst();
        repeat (6) step();
        chk("rst_after_pops", count_pops(), 1);
        chk("rst_after_first_pop", first_pop(), 0);
        check_deliveries("rst_after", 8'h11, 1, 2);

        // enable gating: enable drops right after the first pop
        start_test();
        for (int i = 1; i <= 4; i++) push(i[7:0]);
        m_ready = 1'b1;
        enable  = 1'b1;
        release_rst();
        step();
        enable = 1'b0;
        repeat (6) step();
        chk("ena_pops", count_pops(), 1);
        check_deliveries("ena", 1, 1, 2);
        chk("ena_rdidx", rd_idx, 1);
        chk("ena_empty", {31'd0, empty}, 0);
        enable = 1'b1;
        log_n  = 0;
        repeat (8) step();
        chk("ena_resume_pops", count_pops(), 3);
        check_deliveries("ena_resume", 2, 3, 2);

        // empty boundary: exactly one word
        start_test();
        push(8'hA5);
        m_ready = 1'b1;
        enable  = 1'b1;
        release_rst();
        repeat (6) step();
        chk("one_pops", count_pops(), 1);
        check_deliveries("one", 8'hA5, 1, 2);

        // counter wrap with a 4-bit counter: 17 words
        start_test();
        for (int i = 1; i <= 17; i++) push(i[7:0]);
        m_ready = 1'b1;
        enable  = 1'b1;
        release_rst();
        repeat (24) step();
        check_deliveries("wrap", 1, 17, 2);
        chk("wrap_cnt15", {28'd0, lc[17]}, 15);
        chk("wrap_cnt0", {28'd0, lc[18]}, 0);
        chk("wrap_cnt1", {28'd0, lc[19]}, 1);
        chk("wrap_final", {28'd0, word_cnt}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
